// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a one-cycle-latency memory.
// Issues word-aligned reads, absorbs the registered read latency, buffers
// returned words with their PCs in a small FIFO and hands them downstream
// over a valid/ready handshake. A redirect flushes everything and restarts
// fetch at a new address.

// Run-time checks on the FIFO and the memory address bus.
module fetch_unit_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             reset,
  input logic             push,
  input logic [CNT_W-1:0] count,
  input logic [31:0]      mem_addr
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // A returning word must always find a free FIFO slot.
  ap_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (count < DEPTH_C));

  // Occupancy never exceeds the FIFO size.
  ap_count_bound: assert property (@(posedge clk) disable iff (reset)
    count <= DEPTH_C);

  // Reads are always word aligned.
  ap_addr_aligned: assert property (@(posedge clk) disable iff (reset)
    mem_addr[1:0] == 2'b00);

endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0]      RESET_PC  = RESET_ADDR & 32'hFFFF_FFFC;
  localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  // Fetch side state
  logic [31:0]      fetch_pc_r;
  logic             inflight_r;
  logic [31:0]      inflight_pc_r;

  // FIFO state
  logic [31:0]      fifo_pc_r   [DEPTH];
  logic [31:0]      fifo_word_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Per-cycle control
  logic             pop_s;
  logic             push_s;
  logic             issue_s;
  logic             valid_s;
  logic [CNT_W:0]   occ_s;

  assign valid_s     = (count_r != {CNT_W{1'b0}});
  assign instr_valid = valid_s;
  assign instr       = fifo_word_r[rd_ptr_r];
  assign instr_pc    = fifo_pc_r[rd_ptr_r];
  assign mem_addr    = fetch_pc_r;
  assign mem_rstrb   = issue_s;

  // Decide handshake, read issue and FIFO push for this cycle.
  // occ_s is the number of words that will be buffered or in flight after
  // this cycle's pop; a new read is only issued if it is guaranteed a slot.
  // A read returning during a redirect (or reset) is simply not pushed, and
  // inflight is cleared at that same edge, so nothing stale survives a flush.
  always_comb begin
    pop_s   = 1'b0;
    push_s  = 1'b0;
    issue_s = 1'b0;
    occ_s   = {(CNT_W + 1){1'b0}};
    pop_s   = valid_s && instr_ready;
    occ_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
    if (reset || redirect) begin
      issue_s = 1'b0;
      push_s  = 1'b0;
    end else begin
      issue_s = (occ_s < DEPTH_OCC);
      push_s  = inflight_r;
    end
  end

  // Fetch PC, in-flight flag and the PC of the outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
    end else if (redirect) begin
      fetch_pc_r    <= redirect_pc & 32'hFFFF_FFFC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= inflight_pc_r;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + 32'd4;
      end
    end
  end

  // Instruction FIFO: storage, wrap-around pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]   <= 32'h0000_0000;
        fifo_word_r[i] <= 32'h0000_0000;
      end
    end else if (redirect) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
        fifo_word_r[wr_ptr_r] <= mem_rdata;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_unit_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .count    (count_r),
    .mem_addr (mem_addr)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction/data `Memory` block. Drives the memory read port (`mem_addr`, `mem_rstrb`) and absorbs its one-cycle registered read latency. Buffers fetched words in a small FIFO and presents them, each tagged with its PC, to the decode/execute stage over a valid/ready handshake. A redirect input (jump, branch taken, `CALL`/`RET`) flushes the stage and restarts fetch at a new address.

## Interface
- `RESET_ADDR`, default `32'h0000_0000`: first PC fetched after reset; bits [1:0] ignored (treated as 0).
- `DEPTH`, default `2`: instruction FIFO entries; power of two, legal range 2–8.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_addr`  out  32  read address to memory; always word-aligned (bits [1:0] = 0).
- `mem_rstrb`  out  1  read strobe; one read issued per cycle it is high.
- `mem_rdata`  in  32  memory read data; valid in the cycle after the strobe, held otherwise.
- `instr`  out  32  instruction word at FIFO head.
- `instr_pc`  out  32  byte address of `instr`.
- `instr_valid`  out  1  FIFO head valid.
- `instr_ready`  in  1  consumer accepts head when `instr_valid && instr_ready`.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] forced to 0.

## Operation
- State: `fetch_pc` (32b), `inflight` (1b, read issued last cycle), `drop` (1b, discard returning read), FIFO of `{pc, word}` with `count` (0..DEPTH) and wrap-around read/write pointers.
- `mem_addr = fetch_pc`, combinational. Issue condition: `mem_rstrb = !reset && !redirect && (count + inflight - pop) < DEPTH`, where `pop = instr_valid && instr_ready`. Each issue increments `fetch_pc` by 4 modulo 2^32 (wraps `FFFF_FFFC -> 0000_0000`).
- Return: when `inflight && !drop`, push `{pc_of_inflight, mem_rdata}` into FIFO at the end of that cycle. The issue condition guarantees no push into a full FIFO; push to a full FIFO is an assertion failure.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Redirect (priority over everything except reset): FIFO emptied, `count <= 0`, `fetch_pc <= {redirect_pc[31:2], 2'b00}`, no issue in the redirect cycle. `drop <= 0`, and any read returning in the redirect cycle is discarded. A handshake coinciding with redirect counts as completed for the consumer; the FIFO is flushed regardless.
- Stall: while `instr_valid && !instr_ready`, `instr` and `instr_pc` are held stable.
- Reset values: `fetch_pc = RESET_ADDR & ~3`, `count = 0`, `inflight = 0`, `drop = 0`, `instr_valid = 0`, `mem_rstrb = 0`, `instr = 0`, `instr_pc = 0`. Reset mid-operation discards all buffered and in-flight data. `instr_valid` is low in the cycle after reset is sampled.

## Timing
- Read issued in cycle T: data is sampled from `mem_rdata` at the end of T+1, and `instr_valid` is high in T+2 (FIFO registered, no bypass).
- First cycle with `reset` low = R: read issued in R with `mem_addr = RESET_ADDR`; first `instr_valid` in R+2.
- Redirect in cycle N: first issue in N+1 at the new PC; first `instr_valid` in N+3 with `instr_pc = redirect_pc & ~3`.
- With `instr_ready` held high, throughput is one instruction per cycle for DEPTH ≥ 2.
- Backpressure: at most `DEPTH` words are buffered or in flight; `mem_rstrb` stays low while full.

## Test plan
- Reset release, `instr_ready=1`, memory word i = `0x1000_0000+i` → `instr_valid` 2 cycles after release; `instr_pc` = 0, 4, 8, … with matching words, one per cycle, no gaps.
- After first valid, hold `instr_ready=0` for 6 cycles → `instr`/`instr_pc` frozen at PC 0; exactly 2 reads issued in total, then `mem_rstrb` low. On release, PCs 0, 4, 8 delivered with no loss or duplication.
- Redirect to `0x40` while a read of PC 8 is in flight and FIFO holds PC 4 → PCs 4 and 8 are never presented after the redirect; `instr_pc=0x40` valid exactly 3 cycles after the redirect cycle, followed by 0x44.
- `redirect_pc=0x43` → `mem_addr=0x40` in the next cycle; delivered `instr_pc=0x40`.
- Assert `reset` for 1 cycle mid-stream with FIFO full → `instr_valid` low the next cycle; fetch restarts at `RESET_ADDR` with first valid 2 cycles after release.
- `RESET_ADDR=32'hFFFF_FFF8` → `instr_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
